mult_arbiter: RTL and testbench

- Shares one vdic_dut_2023 16x16 signed multiplier (req/ack/result_rdy handshake, even-parity args and result) between N client requesters.
- Round-robin selects a client and latches its operands. Generates the operand parity bits and sequences the multiplier handshake.
- Returns the 32-bit product to the granted client with parity-error status.
- Sits between client datapath blocks and the multiplier instance.

---
 rtl/mult_arbiter_pkg.sv | 24 ++
 rtl/mult_arbiter_if.sv | 49 ++++
 rtl/mult_arbiter_rr_arbiter.sv | 43 ++++
 rtl/mult_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mult_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mult_arb_pkg : FSM state type, operand/result widths, parity helper
// Rev 1.0
// ----------------------------------------------------------------------------
package mult_arb_pkg;

  localparam int DATA_W = 16;
  localparam int RES_W  = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RES = 2'd2,
    RESP     = 2'd3
  } state_e;

  // Even-parity bit: set when the word holds an odd number of ones.
  function automatic logic even_parity(input logic [31:0] v);
    return ^v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mult_arbiter_if : client-side and multiplier-side signals of mult_arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
interface mult_arbiter_if
  import mult_arb_pkg::*;
#(
  parameter int N = 4
);

  logic [N-1:0]        cli_req;
  logic [N*DATA_W-1:0] cli_arg_a;
  logic [N*DATA_W-1:0] cli_arg_b;
  logic [N-1:0]        cli_ack;
  logic [N-1:0]        cli_done;
  logic [RES_W-1:0]    cli_result;
  logic                cli_arg_par_err;
  logic                cli_res_par_err;
  logic                cli_timeout;

  logic                mul_req;
  logic [DATA_W-1:0]   mul_arg_a;
  logic                mul_arg_a_parity;
  logic [DATA_W-1:0]   mul_arg_b;
  logic                mul_arg_b_parity;
  logic                mul_ack;
  logic [RES_W-1:0]    mul_result;
  logic                mul_result_parity;
  logic                mul_result_rdy;
  logic                mul_arg_parity_error;

  // master: clients plus multiplier; slave: the arbiter between them
  modport master (
    output cli_req, cli_arg_a, cli_arg_b,
    input  cli_ack, cli_done, cli_result, cli_arg_par_err, cli_res_par_err, cli_timeout,
    input  mul_req, mul_arg_a, mul_arg_a_parity, mul_arg_b, mul_arg_b_parity,
    output mul_ack, mul_result, mul_result_parity, mul_result_rdy, mul_arg_parity_error
  );

  modport slave (
    input  cli_req, cli_arg_a, cli_arg_b,
    output cli_ack, cli_done, cli_result, cli_arg_par_err, cli_res_par_err, cli_timeout,
    output mul_req, mul_arg_a, mul_arg_a_parity, mul_arg_b, mul_arg_b_parity,
    input  mul_ack, mul_result, mul_result_parity, mul_result_rdy, mul_arg_parity_error
  );

endinterface
`default_nettype wire

// File: rtl/mult_arbiter_rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick, scanning from last_grant+1 mod N
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  wire logic [N-1:0]  req_i,
  input  wire logic [IW-1:0] last_grant_i,
  output logic      [N-1:0]  grant_o,
  output logic      [IW-1:0] grant_idx_o,
  output logic               valid_o
);

  always_comb begin : p_rr
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    sum         = '0;
    idx         = '0;
    grant_o     = '0;
    grant_idx_o = '0;
    valid_o     = 1'b0;
    // offset N wraps back to last_grant itself, so it has lowest priority
    for (int off = 1; off <= N; off++) begin
      sum = {1'b0, last_grant_i} + (IW+1)'(off);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end
      idx = sum[IW-1:0];
      if (!valid_o && req_i[idx]) begin
        valid_o      = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mult_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mult_arbiter : shares one 16x16 signed multiplier among N round-robin clients
// Optional watchdog: define MULT_ARB_TIMEOUT_EN.                      Rev 1.0
// ----------------------------------------------------------------------------
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N              = 4,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  wire logic      clk,
  input  wire logic      rst,
  mult_arbiter_if.slave  bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if (N < 2 || N > 8 || DATA_W != 16 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("mult_arbiter: unsupported parameter set");
  end

  state_e              state_q, state_d;
  logic [IW-1:0]       gnt_q, last_grant_q, arb_idx;
  logic [N-1:0]        arb_grant, ack_d, done_q, gnt_oh;
  logic                arb_valid;
  logic [DATA_W-1:0]   a_q, b_q, sel_a, sel_b;
  logic                pa_q, pb_q, mul_req_q;
  logic [RES_W-1:0]    result_q;
  logic                arg_err_q, res_err_q;
  logic                take_res, to_fire, to_hit;

  rr_arbiter #(.N(N), .IW(IW)) u_rr (
    .req_i        (bus.cli_req),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant),
    .grant_idx_o  (arb_idx),
    .valid_o      (arb_valid)
  );

  assign sel_a  = bus.cli_arg_a[DATA_W*arb_idx +: DATA_W];
  assign sel_b  = bus.cli_arg_b[DATA_W*arb_idx +: DATA_W];
  assign gnt_oh = N'(1) << gnt_q;

  always_comb begin
    state_d  = state_q;
    ack_d    = '0;
    take_res = 1'b0;
    to_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          ack_d   = arb_grant;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.mul_ack) begin
          if (bus.mul_result_rdy) begin
            take_res = 1'b1;
            state_d  = RESP;
          end else begin
            state_d  = WAIT_RES;
          end
        end else if (to_hit) begin
          to_fire = 1'b1;
          state_d = RESP;
        end
      end
      WAIT_RES: begin
        if (bus.mul_result_rdy) begin
          take_res = 1'b1;
          state_d  = RESP;
        end else if (to_hit) begin
          to_fire = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      last_grant_q <= IW'(N-1);
      mul_req_q    <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      pa_q         <= 1'b0;
      pb_q         <= 1'b0;
      result_q     <= '0;
      arg_err_q    <= 1'b0;
      res_err_q    <= 1'b0;
      done_q       <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= '0;
      if (state_q == IDLE && arb_valid) begin
        gnt_q     <= arb_idx;
        a_q       <= sel_a;
        b_q       <= sel_b;
        pa_q      <= even_parity(RES_W'(sel_a));
        pb_q      <= even_parity(RES_W'(sel_b));
        mul_req_q <= 1'b1;
      end
      if (state_q == ISSUE && bus.mul_ack) begin
        mul_req_q <= 1'b0;
      end
      if (take_res) begin
        result_q  <= bus.mul_result;
        res_err_q <= (bus.mul_result_parity != even_parity(bus.mul_result));
        arg_err_q <= bus.mul_arg_parity_error;
        done_q    <= gnt_oh;
      end
      if (to_fire) begin
        mul_req_q <= 1'b0;
        result_q  <= '0;
        res_err_q <= 1'b0;
        arg_err_q <= 1'b0;
        done_q    <= gnt_oh;
      end
      // Response is valid for the RESP cycle only
      if (state_q == RESP) begin
        result_q     <= '0;
        arg_err_q    <= 1'b0;
        res_err_q    <= 1'b0;
        last_grant_q <= gnt_q;
      end
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1) + 1;

  logic [TO_W-1:0] to_cnt_q;
  logic            to_q;

  assign to_hit = (to_cnt_q >= TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
      to_q     <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        to_cnt_q <= '0;
      end else if (state_q == ISSUE || state_q == WAIT_RES) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
      if (to_fire) begin
        to_q <= 1'b1;
      end else if (state_q == RESP) begin
        to_q <= 1'b0;
      end
    end
  end

  assign bus.cli_timeout = to_q;
`else
  assign to_hit          = 1'b0;
  assign bus.cli_timeout = 1'b0;
`endif

  assign bus.cli_ack          = rst ? '0 : ack_d;
  assign bus.cli_done         = done_q;
  assign bus.cli_result       = result_q;
  assign bus.cli_arg_par_err  = arg_err_q;
  assign bus.cli_res_par_err  = res_err_q;
  assign bus.mul_req          = mul_req_q;
  assign bus.mul_arg_a        = a_q;
  assign bus.mul_arg_a_parity = pa_q;
  assign bus.mul_arg_b        = b_q;
  assign bus.mul_arg_b_parity = pb_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mult_arbiter : directed bench with multiplier model and result scoreboard
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mult_arbiter;
  import mult_arb_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_arbiter_if #(.N(N)) bus ();

  mult_arbiter #(.N(N), .DATA_W(16), .TIMEOUT_CYCLES(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int          cli;
    logic [31:0] res;
    logic        aerr;
    logic        rerr;
    logic        tout;
  } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  exp_t        exp_q[$];
  int          ack_log[$];
  logic [15:0] cli_a [N];
  logic [15:0] cli_b [N];
  logic [31:0] exp_res [N];
  logic        exp_aerr = 1'b0, exp_rerr = 1'b0, exp_tout = 1'b0;
  logic [N-1:0] prev_ack = '0;
  int          prev_cli = 0;
  logic        prev_done = 1'b0;
  logic        seen_pa = 1'b0, seen_pb = 1'b0;
  int          ack_cyc = 0, done_cyc = 0;

  int m_ack_dly = 1, m_res_dly = 2, m_phase = 0, m_cnt = 0;
  bit m_same = 0, m_noack = 0, m_force = 0, m_aerr = 0;

  always @(posedge clk) cyc++;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(int c, logic [15:0] a, logic [15:0] b, logic [31:0] r);
    cli_a[c]   = a;
    cli_b[c]   = b;
    exp_res[c] = r;
    bus.cli_arg_a[16*c +: 16] = a;
    bus.cli_arg_b[16*c +: 16] = b;
    bus.cli_req[c] = 1'b1;
  endtask

  task automatic wait_idle(int budget, string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || bus.cli_req != '0 || m_phase != 0 || bus.mul_req) && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check({name, "_budget"}, (k < budget) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Multiplier model: ack after m_ack_dly cycles of req, result m_res_dly later
  task automatic present();
    logic signed [31:0] p;
    p = $signed(bus.mul_arg_a) * $signed(bus.mul_arg_b);
    if (m_force) begin
      bus.mul_result        = 32'h0000_0001;
      bus.mul_result_parity = 1'b0;
    end else begin
      bus.mul_result        = p;
      bus.mul_result_parity = even_parity(p);
    end
    bus.mul_arg_parity_error = m_aerr;
    bus.mul_result_rdy       = 1'b1;
  endtask

  always @(negedge clk) begin
    bus.mul_ack              = 1'b0;
    bus.mul_result_rdy       = 1'b0;
    bus.mul_arg_parity_error = 1'b0;
    if (rst) begin
      m_phase = 0;
      m_cnt   = 0;
    end else if (m_phase == 0) begin
      if (bus.mul_req && !m_noack) begin
        if (m_cnt >= m_ack_dly) begin
          bus.mul_ack = 1'b1;
          m_cnt = 0;
          if (m_same) present();
          else m_phase = 1;
        end else begin
          m_cnt++;
        end
      end else begin
        m_cnt = 0;
      end
    end else begin
      if (m_cnt >= m_res_dly) begin
        present();
        m_phase = 0;
        m_cnt   = 0;
      end else begin
        m_cnt++;
      end
    end
  end

  // Clients: drop req once the capture edge has passed; log acks into the scoreboard
  always @(negedge clk) begin : p_cli
    int c;
    c = 0;
    if (!rst && prev_ack != '0) begin
      check("mul_req_after_ack", bus.mul_req, 1);
      check("mul_arg_a", bus.mul_arg_a, cli_a[prev_cli]);
      check("mul_arg_b", bus.mul_arg_b, cli_b[prev_cli]);
      check("mul_arg_a_parity", bus.mul_arg_a_parity, even_parity({16'h0, cli_a[prev_cli]}));
      check("mul_arg_b_parity", bus.mul_arg_b_parity, even_parity({16'h0, cli_b[prev_cli]}));
      seen_pa = bus.mul_arg_a_parity;
      seen_pb = bus.mul_arg_b_parity;
    end
    bus.cli_req = bus.cli_req & ~prev_ack;
    prev_ack = bus.cli_ack;
    if (bus.cli_ack != '0) begin
      check("ack_onehot", $countones(bus.cli_ack), 1);
      for (int i = 0; i < N; i++) if (bus.cli_ack[i]) c = i;
      prev_cli = c;
      ack_cyc  = cyc;
      ack_log.push_back(c);
      exp_q.push_back('{c, exp_res[c], exp_aerr, exp_rerr, exp_tout});
    end
  end

  // Monitor: every done pulse is compared against the oldest expected response
  always @(negedge clk) begin : p_mon
    exp_t e;
    if (bus.cli_done != '0) begin
      done_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_done", bus.cli_done, 0);
      end else begin
        e = exp_q.pop_front();
        check("done_client", bus.cli_done, 32'd1 << e.cli);
        check("cli_result", bus.cli_result, e.res);
        check("cli_arg_par_err", bus.cli_arg_par_err, e.aerr);
        check("cli_res_par_err", bus.cli_res_par_err, e.rerr);
        check("cli_timeout", bus.cli_timeout, e.tout);
      end
    end else if (prev_done) begin
      check("result_cleared", bus.cli_result, 0);
      check("flags_cleared", {bus.cli_arg_par_err, bus.cli_res_par_err, bus.cli_timeout}, 0);
    end
    prev_done = (bus.cli_done != '0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cli_req   = '0;
    bus.cli_arg_a = '0;
    bus.cli_arg_b = '0;
    bus.mul_ack = 1'b0; bus.mul_result = '0; bus.mul_result_parity = 1'b0;
    bus.mul_result_rdy = 1'b0; bus.mul_arg_parity_error = 1'b0;
    for (int i = 0; i < N; i++) begin cli_a[i] = '0; cli_b[i] = '0; exp_res[i] = '0; end

    repeat (3) @(negedge clk);
    check("rst_ack", bus.cli_ack, 0);
    check("rst_done", bus.cli_done, 0);
    check("rst_mul_req", bus.mul_req, 0);
    check("rst_result", bus.cli_result, 0);
    check("rst_mul_args", {bus.mul_arg_a, bus.mul_arg_b}, 0);
    sync();
    rst = 1'b0;

    // single client: 3 * -2
    issue(0, 16'd3, 16'hFFFE, 32'hFFFF_FFFA);
    wait_idle(60, "t1");

    // fresh reset, all four together: ack order 0..3
    sync(); rst = 1'b1; sync(); rst = 1'b0;
    ack_log.delete();
    for (int i = 0; i < N; i++) issue(i, 16'(i + 1), 16'd2, 32'(2 * (i + 1)));
    wait_idle(200, "t2");
    check("t2_ack_count", ack_log.size(), 4);
    for (int i = 0; i < ack_log.size(); i++) check("t2_ack_order", ack_log[i], i);

    // ack and result_rdy in the same cycle; most-negative squared
    sync(); m_same = 1;
    issue(1, 16'h8000, 16'h8000, 32'h4000_0000);
    wait_idle(60, "t3");
    m_same = 0;

    // corrupted result parity
    sync(); m_force = 1; exp_rerr = 1'b1;
    issue(2, 16'd5, 16'd7, 32'h0000_0001);
    wait_idle(60, "t4");
    m_force = 0; exp_rerr = 1'b0;

    // multiplier flags an argument parity error; both operand parities are 1
    sync(); m_aerr = 1; exp_aerr = 1'b1;
    issue(1, 16'h7FFF, 16'h8000, 32'hC000_8000);
    wait_idle(60, "t5");
    m_aerr = 0; exp_aerr = 1'b0;
    check("t5_arg_a_parity", seen_pa, 1);
    check("t5_arg_b_parity", seen_pb, 1);

    // a re-requesting client loses to another pending one
    sync(); ack_log.delete();
    issue(2, 16'd100, 16'd100, 32'h0000_2710);
    wait_idle(60, "t6a");
    sync();
    issue(2, 16'hFFFF, 16'hFFFF, 32'h0000_0001);
    issue(3, 16'h7FFF, 16'h7FFF, 32'h3FFF_0001);
    wait_idle(100, "t6b");
    check("t6_ack_count", ack_log.size(), 3);
    if (ack_log.size() == 3) begin
      check("t6_ack0", ack_log[0], 2);
      check("t6_ack1", ack_log[1], 3);
      check("t6_ack2", ack_log[2], 2);
    end

    // reset while waiting for the result: operation discarded, priority restored
    sync(); m_res_dly = 30;
    issue(1, 16'd9, 16'd9, 32'd81);
    for (int k = 0; k < 20 && m_phase != 1; k++) @(negedge clk);
    check("t7_in_wait", m_phase, 1);
    repeat (2) @(negedge clk);
    sync(); rst = 1'b1; sync(); rst = 1'b0;
    @(negedge clk);
    check("t7_mul_req", bus.mul_req, 0);
    check("t7_done", bus.cli_done, 0);
    check("t7_acked", exp_q.size(), 1);
    exp_q.delete();
    repeat (40) @(negedge clk);
    m_res_dly = 2;
    sync(); ack_log.delete();
    issue(3, 16'h1234, 16'h0010, 32'h0001_2340);
    issue(0, 16'hFFF9, 16'd6, 32'hFFFF_FFD6);
    wait_idle(100, "t7");
    check("t7_ack_count", ack_log.size(), 2);
    if (ack_log.size() == 2) begin
      check("t7_ack0", ack_log[0], 0);
      check("t7_ack1", ack_log[1], 3);
    end

`ifdef MULT_ARB_TIMEOUT_EN
    // multiplier never acks: watchdog ends the operation
    sync(); m_noack = 1; exp_tout = 1'b1;
    issue(2, 16'd3, 16'd3, 32'h0);
    wait_idle(200, "t8");
    check("t8_mul_req", bus.mul_req, 0);
    check("t8_latency", done_cyc - ack_cyc, 65);
    m_noack = 0; exp_tout = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
